// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock over a shared datapath,
// round keys muxed live from an externally held key schedule.
//
// state | meaning
// IDLE  | in_ready high, waiting for a plaintext offer
// ROUND | applying rounds 1..10, one per clock
// DONE  | ciphertext presented, waiting for out_ready

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] acc;
    t   = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gf_mul(t, t);
      acc = gf_mul(acc, t);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  assign inv  = gf_inv(din);
  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_encrypt_core #(
  parameter int WORD_LENGTH = 32,
  parameter int Nb          = 4,
  parameter int Nr          = 10
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [127:0]                        plaintext,
  input  logic [Nb*(Nr+1)*WORD_LENGTH-1:0]    key_schedule,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [127:0]                        ciphertext,
  output logic                                busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   round;
  logic [127:0] state_reg, ct_reg;
  logic [127:0] rk_sel, sb_out, sr_out, mc_out, round_out;
  logic         round_ok, last_round, accept;

  assign round_ok   = (round >= 4'd1) && (round <= 4'(Nr));
  assign last_round = (round == 4'(Nr));
  assign accept     = in_valid && (state == IDLE);

  assign in_ready   = (state == IDLE);
  assign busy       = (state == ROUND);
  assign out_valid  = (state == DONE);
  assign ciphertext = ct_reg;

  // Out-of-range round values select an all-zero key; the FSM aborts on them anyway.
  always_comb begin
    rk_sel = '0;
    for (int r = 0; r <= Nr; r++) begin
      if (round == 4'(r)) rk_sel = key_schedule[128*r +: 128];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (state_reg[127-8*i -: 8]),
      .dout (sb_out[127-8*i -: 8])
    );
  end

  always_comb begin
    sr_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr_out[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc_out[127-32*c -: 32] = mix_col(sr_out[127-32*c -: 32]);
  end

  assign round_out = (last_round ? sr_out : mc_out) ^ rk_sel;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = ROUND;
      ROUND: begin
        if (!round_ok)       state_nxt = IDLE;
        else if (last_round) state_nxt = DONE;
      end
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round     <= 4'd0;
      state_reg <= '0;
      ct_reg    <= '0;
    end else if (accept) begin
      state_reg <= plaintext ^ key_schedule[127:0];
      round     <= 4'd1;
    end else if (state == ROUND && round_ok) begin
      state_reg <= round_out;
      round     <= round + 4'd1;
      if (last_round) ct_reg <= round_out;
    end
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: FIPS-197 vectors plus random blocks
// checked against a byte-array AES model with its own key expansion.
`timescale 1ns/1ps

module tb_aes_encrypt_core;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, busy;
  logic [127:0]  plaintext = '0;
  logic [127:0]  ciphertext;
  logic [1407:0] key_schedule = '0;

  int n_cmp = 0, n_err = 0, n_out = 0, n_push = 0, cyc = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t[256];
  logic         rand_ready = 1'b0;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_encrypt_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plaintext    (plaintext),
    .key_schedule (key_schedule),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ciphertext   (ciphertext),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: plain polynomial product reduced mod 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] q, input int n);
    return (q << n) | (q >> (8 - n));
  endfunction

  // Walk the multiplicative group with generator 3 alongside its inverse.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = gmul(p, 8'h03);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [1407:0] ks);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    rk = ks[127:0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      rk = ks[128*r +: 128];
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++) s[row+4*col] = t[row+4*((col+row)%4)];
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Monitor: every output handshake pops one expected ciphertext.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h with nothing expected", ciphertext);
      end else begin
        chk("ciphertext", ciphertext, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [127:0] pt, input logic [1407:0] ks,
                      input logic [127:0] exp, output int acc);
    int t;
    t   = 0;
    acc = -1;
    while (!in_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'(1));
      return;
    end
    plaintext    = pt;
    key_schedule = ks;
    in_valid     = 1'b1;
    exp_q.push_back(exp);
    n_push++;
    @(posedge clk); #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, edges, nbusy, cnt;
    logic [127:0]  pt, key;
    logic [1407:0] ks;

    init_sbox();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ciphertext", ciphertext, 128'h0);

    // FIPS-197 C.1 with latency and busy-length checks
    out_ready = 1'b1;
    send(PT_C1, expand_key(KEY_C1), CT_C1, a1);
    edges = 0;
    nbusy = 0;
    while (!out_valid && edges < 100) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      edges++;
    end
    // accept cycle plus ten round edges = 11 cycles to out_valid
    chk("latency_edges", 128'(edges), 128'(10));
    chk("busy_cycles", 128'(nbusy), 128'(10));
    drain();

    // App. B then zero key/zero pt back-to-back
    send(PT_B, expand_key(KEY_B), CT_B, a1);
    send(128'h0, expand_key(128'h0), CT_Z, a2);
    chk("accept_spacing", 128'(a2 - a1), 128'(12));
    drain();

    // Back-pressure
    out_ready = 1'b0;
    send(PT_C1, expand_key(KEY_C1), CT_C1, a1);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("bp_out_valid", 128'(out_valid), 128'(1));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid  = 1'b1;
        plaintext = PT_B;
      end else begin
        in_valid = 1'b0;
      end
      chk("bp_ciphertext", ciphertext, CT_C1);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_still_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_post_valid", 128'(out_valid), 128'(0));
    chk("bp_post_in_ready", 128'(in_ready), 128'(1));
    chk("bp_ct_hold", ciphertext, CT_C1);
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("bp_ignored_pulse", 128'(cnt), 128'(0));

    // Reset in the middle of round 5
    out_ready = 1'b1;
    pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    ks  = expand_key(key);
    send(pt, ks, model_enc(pt, ks), a1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_ciphertext", ciphertext, 128'h0);
    exp_q.delete();
    n_push--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("no_out_after_reset", 128'(cnt), 128'(0));
    send(PT_C1, expand_key(KEY_C1), CT_C1, a1);
    drain();

    // Random blocks against the model with random back-pressure and gaps
    rand_ready = 1'b1;
    for (int b = 0; b < 30; b++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      ks  = expand_key(key);
      send(pt, ks, model_enc(pt, ks), a1);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    chk("output_count", 128'(n_out), 128'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
